// File: rtl/buzzer_sched.sv
// Buzzer scheduler: arbitrates over-temperature, alarm and hourly chime onto one active-low buzzer.
// Outputs are registered; a request preempts on the next clock and key_ack acts only on the source shown on src.
module buzzer_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1ms,
    input  logic [23:0] temp,
    input  logic [23:0] temp_thr,
    input  logic [23:0] temp_hyst,
    input  logic        alarm_req,
    input  logic        chime_req,
    input  logic        key_ack,
    output logic        buzzer,
    output logic        led,
    output logic [1:0]  src
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TEMP  = 2'd1,
        ALARM = 2'd2,
        CHIME = 2'd3
    } state_t;

    state_t      state, state_n;
    logic        temp_over, temp_over_n;
    logic        temp_mute, temp_mute_n;
    logic        alarm_pend, alarm_pend_n;
    logic        chime_pend, chime_pend_n, chime_keep;
    logic        temp_req_n;
    logic [8:0]  ms_cnt, ms_cnt_n, phase_len;
    logic        phase_on, phase_on_n;
    logic [1:0]  beep_cnt, beep_cnt_n;
    logic [15:0] alarm_ms, alarm_ms_n;
    logic [23:0] clr_lvl;
    logic        phase_end, chime_done, alarm_expire;
    logic        buzzer_n;

    assign clr_lvl = (temp_thr > temp_hyst) ? (temp_thr - temp_hyst) : 24'd0;

    always_comb begin
        phase_len = 9'd1;
        case (state)
            TEMP:    phase_len = 9'd100;
            ALARM:   phase_len = 9'd500;
            CHIME:   phase_len = phase_on ? 9'd200 : 9'd300;
            default: phase_len = 9'd1;
        endcase
    end

    assign phase_end    = tick_1ms && (state != IDLE) && ((ms_cnt + 9'd1) == phase_len);
    assign chime_done   = (state == CHIME) && phase_end && !phase_on && (beep_cnt == 2'd2);
    assign alarm_expire = (state == ALARM) && tick_1ms && (alarm_ms == 16'd59999);

    // Request flags are resolved combinationally so the arbiter sees this cycle's set/clear events.
    always_comb begin
        temp_over_n = temp_over;
        if (temp >= temp_thr)
            temp_over_n = 1'b1;
        else if (temp < clr_lvl)
            temp_over_n = 1'b0;

        temp_mute_n = temp_mute;
        if (key_ack && (state == TEMP))
            temp_mute_n = 1'b1;
        if (!temp_over_n)
            temp_mute_n = 1'b0;
        temp_req_n = temp_over_n && !temp_mute_n;

        alarm_pend_n = alarm_pend;
        if (alarm_req)
            alarm_pend_n = 1'b1;
        else if ((key_ack && (state == ALARM)) || alarm_expire)
            alarm_pend_n = 1'b0;

        chime_keep = chime_pend;
        if (chime_req)
            chime_keep = 1'b1;
        else if ((key_ack && (state == CHIME)) || chime_done)
            chime_keep = 1'b0;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // FSM: next state by fixed priority
    always_comb begin
        state_n = IDLE;
        if (temp_req_n)
            state_n = TEMP;
        else if (alarm_pend_n)
            state_n = ALARM;
        else if (chime_keep)
            state_n = CHIME;
    end

    // A preempted chime is dropped rather than resumed.
    assign chime_pend_n = chime_keep &&
        !((state == CHIME) && !chime_req && ((state_n == TEMP) || (state_n == ALARM)));

    always_comb begin
        ms_cnt_n   = ms_cnt;
        phase_on_n = phase_on;
        beep_cnt_n = beep_cnt;
        if ((state_n == IDLE) || (state_n != state)) begin
            ms_cnt_n   = 9'd0;
            phase_on_n = 1'b1;
            beep_cnt_n = 2'd0;
        end else if (phase_end) begin
            ms_cnt_n   = 9'd0;
            phase_on_n = !phase_on;
            if (!phase_on)
                beep_cnt_n = beep_cnt + 2'd1;
        end else if (tick_1ms) begin
            ms_cnt_n = ms_cnt + 9'd1;
        end

        alarm_ms_n = alarm_ms;
        if (alarm_req || alarm_expire)
            alarm_ms_n = 16'd0;
        else if ((state == ALARM) && tick_1ms)
            alarm_ms_n = alarm_ms + 16'd1;
    end

    // FSM: output decode from next state and phase
    always_comb begin
        buzzer_n = !((state_n != IDLE) && phase_on_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            temp_over  <= 1'b0;
            temp_mute  <= 1'b0;
            alarm_pend <= 1'b0;
            chime_pend <= 1'b0;
            ms_cnt     <= 9'd0;
            phase_on   <= 1'b1;
            beep_cnt   <= 2'd0;
            alarm_ms   <= 16'd0;
            buzzer     <= 1'b1;
            led        <= 1'b1;
        end else begin
            temp_over  <= temp_over_n;
            temp_mute  <= temp_mute_n;
            alarm_pend <= alarm_pend_n;
            chime_pend <= chime_pend_n;
            ms_cnt     <= ms_cnt_n;
            phase_on   <= phase_on_n;
            beep_cnt   <= beep_cnt_n;
            alarm_ms   <= alarm_ms_n;
            buzzer     <= buzzer_n;
            led        <= !temp_over;
        end
    end

    assign src = state;

endmodule

// File: tb/tb_buzzer_sched.sv
// Bench for buzzer_sched: directed scenarios plus randomized traffic against an elapsed-time reference model.
module tb_buzzer_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1ms = 1'b0;
    logic [23:0] temp = 24'd0;
    logic [23:0] temp_thr = 24'd300000;
    logic [23:0] temp_hyst = 24'd5000;
    logic        alarm_req = 1'b0;
    logic        chime_req = 1'b0;
    logic        key_ack = 1'b0;
    logic        buzzer;
    logic        led;
    logic [1:0]  src;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: source, ms elapsed since entering it, alarm ms consumed, request flags
    int m_src, m_elapsed, m_aticks;
    bit m_over, m_mute, m_alarm, m_chime, m_led, m_buzzer;

    buzzer_sched dut (
        .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .temp(temp), .temp_thr(temp_thr),
        .temp_hyst(temp_hyst), .alarm_req(alarm_req), .chime_req(chime_req), .key_ack(key_ack),
        .buzzer(buzzer), .led(led), .src(src)
    );

    always #5 clk = ~clk;

    function automatic bit sounding(int s, int e);
        case (s)
            1: return (e % 200) < 100;
            2: return (e % 1000) < 500;
            3: return (e % 500) < 200;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_src = 0; m_elapsed = 0; m_aticks = 0;
        m_over = 0; m_mute = 0; m_alarm = 0; m_chime = 0;
        m_led = 1; m_buzzer = 1;
    endtask

    task automatic model_edge();
        int clr, cur, nxt;
        cur   = m_src;
        m_led = !m_over;
        clr   = (int'(temp_thr) > int'(temp_hyst)) ? int'(temp_thr) - int'(temp_hyst) : 0;
        if (int'(temp) >= int'(temp_thr)) m_over = 1;
        else if (int'(temp) < clr) m_over = 0;
        if (cur == 1 && key_ack) m_mute = 1;
        if (!m_over) m_mute = 0;
        if (cur != 0 && tick_1ms) m_elapsed++;
        if (cur == 2 && tick_1ms) begin
            m_aticks++;
            if (m_aticks >= 60000) m_alarm = 0;
        end
        if (cur == 2 && key_ack) m_alarm = 0;
        if (alarm_req) begin m_alarm = 1; m_aticks = 0; end
        if (cur == 3 && m_elapsed >= 1500) m_chime = 0;
        if (cur == 3 && key_ack) m_chime = 0;
        if (chime_req) m_chime = 1;
        nxt = (m_over && !m_mute) ? 1 : m_alarm ? 2 : m_chime ? 3 : 0;
        if (cur == 3 && (nxt == 1 || nxt == 2) && !chime_req) m_chime = 0;
        if (nxt != cur) m_elapsed = 0;
        m_src    = nxt;
        m_buzzer = (nxt == 0) ? 1'b1 : !sounding(nxt, m_elapsed);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        step(); step();
        n_checks++;
        if (buzzer !== 1'b1) begin n_fail++; $display("FAIL reset_buzzer: got %b expected 1", buzzer); end
        n_checks++;
        if (led !== 1'b1) begin n_fail++; $display("FAIL reset_led: got %b expected 1", led); end
        n_checks++;
        if (src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d expected 0", src); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_temp_hyst();
        int trans_n = 0;
        int bad_pos = 0;
        logic prev;
        temp_thr = 24'd300000; temp_hyst = 24'd5000; tick_1ms = 1'b1;
        temp = 24'd299999;
        repeat (3) step();
        n_checks++;
        if (src !== 2'd0) begin n_fail++; $display("FAIL temp_below_thr_src: got %0d expected 0", src); end
        temp = 24'd300000;
        step();
        n_checks++;
        if (src !== 2'd1) begin n_fail++; $display("FAIL temp_enter_src: got %0d expected 1", src); end
        n_checks++;
        if (buzzer !== 1'b0) begin n_fail++; $display("FAIL temp_enter_buzzer: got %b expected 0", buzzer); end
        prev = buzzer;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (buzzer !== prev) begin
                trans_n++;
                if (k % 100 != 0) bad_pos++;
            end
            prev = buzzer;
            n_checks++;
            if (buzzer !== m_buzzer) begin n_fail++; $display("FAIL temp_pattern k=%0d: got %b expected %b", k, buzzer, m_buzzer); end
        end
        n_checks++;
        if (led !== 1'b0) begin n_fail++; $display("FAIL temp_led_on: got %b expected 0", led); end
        n_checks++;
        if (trans_n != 4 || bad_pos != 0) begin
            n_fail++; $display("FAIL temp_toggle_period: got %0d toggles (%0d off-grid) expected 4 on 100-tick grid", trans_n, bad_pos);
        end
        temp = 24'd296000;
        repeat (50) step();
        n_checks++;
        if (src !== 2'd1) begin n_fail++; $display("FAIL temp_hold_in_hyst: got %0d expected 1", src); end
        temp = 24'd294999;
        step();
        n_checks++;
        if (src !== 2'd0) begin n_fail++; $display("FAIL temp_clear_src: got %0d expected 0", src); end
        step();
        n_checks++;
        if (led !== 1'b1) begin n_fail++; $display("FAIL temp_clear_led: got %b expected 1", led); end
    endtask

    task automatic test_chime();
        bit bz [0:1700];
        logic [1:0] sv [0:1700];
        int starts[$];
        int lens[$];
        int run = 0;
        tick_1ms = 1'b1; temp = 24'd0;
        chime_req = 1'b1;
        step();
        chime_req = 1'b0;
        bz[0] = buzzer; sv[0] = src;
        for (int k = 1; k <= 1700; k++) begin
            step();
            bz[k] = buzzer; sv[k] = src;
            n_checks++;
            if (buzzer !== m_buzzer || src !== 2'(m_src)) begin
                n_fail++; $display("FAIL chime_model k=%0d: got buzzer=%b src=%0d expected buzzer=%b src=%0d", k, buzzer, src, m_buzzer, m_src);
            end
        end
        for (int k = 0; k <= 1700; k++) begin
            if (bz[k] == 1'b0) begin
                if (run == 0) starts.push_back(k);
                run++;
            end else if (run > 0) begin
                lens.push_back(run);
                run = 0;
            end
        end
        n_checks++;
        if (lens.size() != 3 || starts.size() != 3) begin
            n_fail++; $display("FAIL chime_beep_count: got %0d expected 3", lens.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (lens[i] != 200 || starts[i] != 500 * i) begin
                    n_fail++; $display("FAIL chime_beep%0d: got start=%0d len=%0d expected start=%0d len=200", i, starts[i], lens[i], 500 * i);
                end
            end
        end
        n_checks++;
        if (sv[1499] !== 2'd3 || sv[1500] !== 2'd0) begin
            n_fail++; $display("FAIL chime_end_src: got %0d/%0d expected 3/0", sv[1499], sv[1500]);
        end
    endtask

    task automatic test_alarm_preempt_timeout();
        int seg1 = 0;
        int seg2 = 0;
        bit done = 0;
        tick_1ms = 1'b1; temp = 24'd0;
        alarm_req = 1'b1;
        step();
        alarm_req = 1'b0;
        n_checks++;
        if (src !== 2'd2) begin n_fail++; $display("FAIL alarm_enter_src: got %0d expected 2", src); end
        seg1 = 1;
        for (int k = 0; k < 20000 && seg1 < 10000; k++) begin
            step();
            if (src === 2'd2) seg1++;
            n_checks++;
            if (buzzer !== m_buzzer) begin n_fail++; $display("FAIL alarm_pattern: got %b expected %b", buzzer, m_buzzer); end
        end
        temp = 24'd300000;
        step();
        n_checks++;
        if (src !== 2'd1) begin n_fail++; $display("FAIL alarm_preempt_src: got %0d expected 1", src); end
        repeat (300) step();
        key_ack = 1'b1;
        step();
        key_ack = 1'b0;
        n_checks++;
        if (src !== 2'd2) begin n_fail++; $display("FAIL alarm_resume_src: got %0d expected 2", src); end
        seg2 = 1;
        for (int k = 0; k < 60000 && !done; k++) begin
            step();
            if (src === 2'd2) seg2++; else done = 1;
        end
        n_checks++;
        if (!done || seg2 != 50000) begin
            n_fail++; $display("FAIL alarm_timeout_remaining: got %0d ms (ended=%0d) expected 50000", seg2, done);
        end
        n_checks++;
        if (src !== 2'(m_src) || src !== 2'd0) begin n_fail++; $display("FAIL alarm_after_timeout: got %0d expected 0", src); end
        temp = 24'd0;
        step(); step();
    endtask

    task automatic test_ack_temp();
        tick_1ms = 1'b1;
        temp = 24'd300000;
        step();
        n_checks++;
        if (src !== 2'd1) begin n_fail++; $display("FAIL ack_temp_enter: got %0d expected 1", src); end
        key_ack = 1'b1;
        step();
        key_ack = 1'b0;
        n_checks++;
        if (src !== 2'd0) begin n_fail++; $display("FAIL ack_temp_silence: got %0d expected 0", src); end
        repeat (5) step();
        n_checks++;
        if (led !== 1'b0 || buzzer !== 1'b1) begin
            n_fail++; $display("FAIL ack_temp_led_stays: got led=%b buzzer=%b expected led=0 buzzer=1", led, buzzer);
        end
        temp = 24'd290000;
        step(); step();
        n_checks++;
        if (led !== 1'b1) begin n_fail++; $display("FAIL ack_temp_clear_led: got %b expected 1", led); end
        temp = 24'd300001;
        step();
        n_checks++;
        if (src !== 2'd1) begin n_fail++; $display("FAIL ack_temp_reenter: got %0d expected 1", src); end
        temp = 24'd0;
        step(); step();
    endtask

    task automatic test_reset_mid_chime();
        tick_1ms = 1'b1;
        chime_req = 1'b1;
        step();
        chime_req = 1'b0;
        repeat (150) step();
        alarm_req = 1'b1;
        step();
        alarm_req = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (buzzer !== 1'b1 || src !== 2'd0) begin
            n_fail++; $display("FAIL rst_immediate: got buzzer=%b src=%0d expected 1/0", buzzer, src);
        end
        @(negedge clk);
        step();
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            n_checks++;
            if (src !== 2'd0 || buzzer !== 1'b1) begin
                n_fail++; $display("FAIL rst_no_resume k=%0d: got src=%0d buzzer=%b expected 0/1", k, src, buzzer);
            end
        end
    endtask

    task automatic test_random();
        temp_thr  = 24'($urandom_range(5000, 1000));
        temp_hyst = 24'($urandom_range(6000, 0));
        for (int k = 0; k < 4000; k++) begin
            if (k == 2000) begin
                temp_thr  = 24'd3000;
                temp_hyst = 24'd5000;
            end
            tick_1ms  = 1'($urandom_range(1, 0));
            temp      = 24'($urandom_range(int'(temp_thr) + 500, (int'(temp_thr) > 6500) ? int'(temp_thr) - 6500 : 0));
            alarm_req = ($urandom_range(299, 0) == 0);
            chime_req = ($urandom_range(149, 0) == 0);
            key_ack   = ($urandom_range(39, 0) == 0);
            step();
            n_checks++;
            if (src !== 2'(m_src) || buzzer !== m_buzzer || led !== m_led) begin
                n_fail++;
                $display("FAIL random k=%0d: got src=%0d buzzer=%b led=%b expected src=%0d buzzer=%b led=%b",
                         k, src, buzzer, led, m_src, m_buzzer, m_led);
            end
        end
        alarm_req = 1'b0; chime_req = 1'b0; key_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_temp_hyst();
        test_chime();
        test_alarm_preempt_timeout();
        test_ack_temp();
        test_reset_mid_chime();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
